// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-stage pipeline: tracks EX/MEM destinations,
// resolves RAW stalls, branch flushes and memory freezes, and counts stalls and flushes.
module pipe_hazard_ctrl #(
  parameter int SIZE      = 32,
  parameter int CNT_W     = 16,
  parameter int WB_BYPASS = 0,
  localparam int REG_W    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_dst,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_FLUSH,
    MODE_STALL,
    MODE_NORMAL
  } mode_t;

  localparam logic MEM_HAZARD = (WB_BYPASS == 0);

  logic             ex_v;
  logic [REG_W-1:0] ex_d;
  logic             mem_v;
  logic [REG_W-1:0] mem_d;

  logic  hit_rs;
  logic  hit_rt;
  logic  raw;
  mode_t mode;

  // With a write-first register file the MEM/WB producer is already visible to ID.
  assign hit_rs = (ex_v && ex_d == id_rs) || (MEM_HAZARD && mem_v && mem_d == id_rs);
  assign hit_rt = (ex_v && ex_d == id_rt) || (MEM_HAZARD && mem_v && mem_d == id_rt);

  assign raw = id_valid &&
               ((id_uses_rs && id_rs != '0 && hit_rs) ||
                (id_uses_rt && id_rt != '0 && hit_rt));

  always_comb begin
    if (rst)
      mode = MODE_RESET;
    else if (mem_busy)
      mode = MODE_FREEZE;
    else if (ex_branch_taken)
      mode = MODE_FLUSH;
    else if (raw)
      mode = MODE_STALL;
    else
      mode = MODE_NORMAL;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    stall       = 1'b0;
    case (mode)
      MODE_RESET: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_en     = 1'b0;
        idex_bubble = 1'b1;
        exmem_en    = 1'b0;
      end
      MODE_FREEZE: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        stall    = 1'b1;
      end
      MODE_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      MODE_STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        stall       = 1'b1;
      end
      MODE_NORMAL: begin
      end
      default: begin
      end
    endcase
  end

  // A bubble or flushed slot entering EX never carries a destination, so ex_v drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v        <= 1'b0;
      ex_d        <= '0;
      mem_v       <= 1'b0;
      mem_d       <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          mem_v <= ex_v;
          mem_d <= ex_d;
          ex_v  <= 1'b0;
          if (flush_count != '1)
            flush_count <= flush_count + 1'b1;
        end
        MODE_STALL: begin
          mem_v <= ex_v;
          mem_d <= ex_d;
          ex_v  <= 1'b0;
          if (stall_count != '1)
            stall_count <= stall_count + 1'b1;
        end
        MODE_NORMAL: begin
          mem_v <= ex_v;
          mem_d <= ex_d;
          ex_v  <= id_valid && id_writes && id_dst != '0;
          ex_d  <= id_dst;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: three instances (no bypass, bypass, 4-bit counters)
// driven by shared stimulus and compared against a register-set reference model and fixed vectors.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_N = 7'b1101010;
  localparam logic [6:0] C_S = 7'b0001111;
  localparam logic [6:0] C_F = 7'b1111110;
  localparam logic [6:0] C_Z = 7'b0000001;
  localparam logic [6:0] C_R = 7'b0010100;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wr;
    logic [4:0] dst;
    logic       br;
    logic       busy;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
    int         sc_a;
    int         sc_b;
    int         fc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_writes;
  logic [4:0] id_dst;
  logic       ex_branch_taken;
  logic       mem_busy;

  logic        pc_a, ife_a, iff_a, ide_a, idb_a, exe_a, st_a;
  logic        pc_b, ife_b, iff_b, ide_b, idb_b, exe_b, st_b;
  logic        pc_c, ife_c, iff_c, ide_c, idb_c, exe_c, st_c;
  logic [15:0] sc_a, fc_a, sc_b, fc_b;
  logic [3:0]  sc_c, fc_c;

  logic [6:0]  act_ctrl [3];
  logic [31:0] act_sc [3];
  logic [31:0] act_fc [3];

  int tests  = 0;
  int failed = 0;

  int m_ex [3];
  int m_mem [3];
  int m_sc [3];
  int m_fc [3];
  bit m_known = 1'b0;
  int m_wbp [3]  = '{0, 1, 0};
  int m_cmax [3] = '{65535, 65535, 15};

  vec_t tbl [21];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.SIZE(32), .CNT_W(16), .WB_BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writes(id_writes), .id_dst(id_dst),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_a), .ifid_en(ife_a), .ifid_flush(iff_a), .idex_en(ide_a), .idex_bubble(idb_a),
    .exmem_en(exe_a), .stall(st_a), .stall_count(sc_a), .flush_count(fc_a));

  pipe_hazard_ctrl #(.SIZE(32), .CNT_W(16), .WB_BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writes(id_writes), .id_dst(id_dst),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_b), .ifid_en(ife_b), .ifid_flush(iff_b), .idex_en(ide_b), .idex_bubble(idb_b),
    .exmem_en(exe_b), .stall(st_b), .stall_count(sc_b), .flush_count(fc_b));

  pipe_hazard_ctrl #(.SIZE(32), .CNT_W(4), .WB_BYPASS(0)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_writes(id_writes), .id_dst(id_dst),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_c), .ifid_en(ife_c), .ifid_flush(iff_c), .idex_en(ide_c), .idex_bubble(idb_c),
    .exmem_en(exe_c), .stall(st_c), .stall_count(sc_c), .flush_count(fc_c));

  assign act_ctrl[0] = {pc_a, ife_a, iff_a, ide_a, idb_a, exe_a, st_a};
  assign act_ctrl[1] = {pc_b, ife_b, iff_b, ide_b, idb_b, exe_b, st_b};
  assign act_ctrl[2] = {pc_c, ife_c, iff_c, ide_c, idb_c, exe_c, st_c};
  assign act_sc[0] = {16'd0, sc_a};
  assign act_sc[1] = {16'd0, sc_b};
  assign act_sc[2] = {28'd0, sc_c};
  assign act_fc[0] = {16'd0, fc_a};
  assign act_fc[1] = {16'd0, fc_b};
  assign act_fc[2] = {28'd0, fc_c};

  function automatic vec_t mk(input logic r, input logic v, input int rs, input int rt,
                              input logic urs, input logic urt, input logic wr, input int dst,
                              input logic br, input logic busy, input logic [6:0] ea,
                              input logic [6:0] eb, input int sca, input int scb, input int fc);
    vec_t x;
    x.rst = r; x.valid = v; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt;
    x.wr = wr; x.dst = 5'(dst); x.br = br; x.busy = busy; x.exp_a = ea; x.exp_b = eb;
    x.sc_a = sca; x.sc_b = scb; x.fc = fc;
    return x;
  endfunction

  function automatic vec_t idle(input logic r);
    return mk(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, C_N, 0, 0, 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model keeps the destination register of each in-flight instruction (0 = none).
  function automatic bit in_flight(input int i, input int r);
    if (r == 0) return 1'b0;
    return (r == m_ex[i]) || (m_wbp[i] == 0 && r == m_mem[i]);
  endfunction

  task automatic applyStimulus(input vec_t v);
    bit          raw;
    logic [6:0]  exp;
    @(negedge clk);
    rst = v.rst; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_writes = v.wr; id_dst = v.dst;
    ex_branch_taken = v.br; mem_busy = v.busy;
    #1;
    for (int i = 0; i < 3; i++) begin
      raw = v.valid && ((v.urs && in_flight(i, int'(v.rs))) || (v.urt && in_flight(i, int'(v.rt))));
      if (v.rst)       exp = C_R;
      else if (v.busy) exp = C_Z;
      else if (v.br)   exp = C_F;
      else if (raw)    exp = C_S;
      else             exp = C_N;
      checkOutput($sformatf("model_ctrl[%0d]", i), {25'd0, act_ctrl[i]}, {25'd0, exp});
      if (m_known) begin
        checkOutput($sformatf("model_stall_count[%0d]", i), act_sc[i], m_sc[i]);
        checkOutput($sformatf("model_flush_count[%0d]", i), act_fc[i], m_fc[i]);
      end
      if (v.rst) begin
        m_ex[i] = 0; m_mem[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else if (!v.busy) begin
        m_mem[i] = m_ex[i];
        if (v.br) begin
          m_ex[i] = 0;
          if (m_fc[i] < m_cmax[i]) m_fc[i]++;
        end else if (raw) begin
          m_ex[i] = 0;
          if (m_sc[i] < m_cmax[i]) m_sc[i]++;
        end else begin
          m_ex[i] = (v.valid && v.wr) ? int'(v.dst) : 0;
        end
      end
    end
    if (v.rst) m_known = 1'b1;
  endtask

  task automatic dependentPair();
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, C_N, C_N, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      applyStimulus(mk(0, 1, 10, 0, 1, 0, 0, 0, 0, 0, C_N, C_N, 0, 0, 0));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_writes = 1'b0; id_dst = '0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

    for (int k = 0; k < 2; k++) begin
      applyStimulus(idle(1));
      checkOutput("reset_ctrl", {25'd0, act_ctrl[0]}, {25'd0, C_R});
    end

    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, C_N, C_N, 0, 0, 0);
    tbl[1]  = mk(0, 1, 3, 4, 1, 1, 1, 5, 0, 0, C_S, C_S, 0, 0, 0);
    tbl[2]  = mk(0, 1, 3, 4, 1, 1, 1, 5, 0, 0, C_S, C_N, 1, 1, 0);
    tbl[3]  = mk(0, 1, 3, 4, 1, 1, 1, 5, 0, 0, C_N, C_N, 2, 1, 0);
    tbl[4]  = mk(0, 1, 6, 7, 1, 1, 1, 0, 0, 0, C_N, C_N, 2, 1, 0);
    tbl[5]  = mk(0, 1, 5, 0, 1, 0, 0, 0, 1, 0, C_F, C_F, 2, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, C_N, 2, 1, 1);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 1, 8, 0, 0, C_N, C_N, 2, 1, 1);
    tbl[8]  = mk(0, 1, 1, 8, 1, 1, 0, 0, 0, 0, C_S, C_S, 2, 1, 1);
    tbl[9]  = mk(0, 1, 1, 8, 1, 1, 0, 0, 0, 1, C_Z, C_Z, 3, 2, 1);
    tbl[10] = mk(0, 1, 1, 8, 1, 1, 0, 0, 0, 1, C_Z, C_Z, 3, 2, 1);
    tbl[11] = mk(0, 1, 1, 8, 1, 1, 0, 0, 0, 1, C_Z, C_Z, 3, 2, 1);
    tbl[12] = mk(0, 1, 1, 8, 1, 1, 0, 0, 0, 0, C_S, C_N, 3, 2, 1);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, C_N, C_N, 4, 2, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_Z, C_Z, 4, 2, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_F, C_F, 4, 2, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, C_N, 4, 2, 2);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_R, C_R, 4, 2, 2);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N, C_N, 0, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, C_N, C_N, 0, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, C_N, C_N, 0, 0, 0);

    for (int r = 0; r < 21; r++) begin
      applyStimulus(tbl[r]);
      checkOutput($sformatf("vec%0d_ctrl_nobypass", r), {25'd0, act_ctrl[0]}, {25'd0, tbl[r].exp_a});
      checkOutput($sformatf("vec%0d_ctrl_bypass", r), {25'd0, act_ctrl[1]}, {25'd0, tbl[r].exp_b});
      checkOutput($sformatf("vec%0d_stall_count_nobypass", r), act_sc[0], tbl[r].sc_a);
      checkOutput($sformatf("vec%0d_stall_count_bypass", r), act_sc[1], tbl[r].sc_b);
      checkOutput($sformatf("vec%0d_flush_count", r), act_fc[0], tbl[r].fc);
    end

    // Twenty back-to-back dependent stalls saturate the 4-bit counter.
    applyStimulus(idle(1));
    for (int k = 0; k < 10; k++) dependentPair();
    applyStimulus(idle(0));
    checkOutput("sat_stall_count_cnt4", act_sc[2], 15);
    checkOutput("sat_stall_count_cnt16", act_sc[0], 20);
    checkOutput("sat_stall_count_bypass", act_sc[1], 10);
    for (int k = 0; k < 3; k++) dependentPair();
    applyStimulus(idle(0));
    checkOutput("sat_hold_cnt4", act_sc[2], 15);
    checkOutput("sat_hold_cnt16", act_sc[0], 26);

    for (int k = 0; k < 400; k++) begin
      v = idle($urandom_range(0, 31) == 0);
      v.valid = 1'($urandom_range(0, 7) != 0);
      v.rs    = 5'($urandom_range(0, 7));
      v.rt    = 5'($urandom_range(0, 7));
      v.urs   = 1'($urandom_range(0, 1));
      v.urt   = 1'($urandom_range(0, 1));
      v.wr    = 1'($urandom_range(0, 3) != 0);
      v.dst   = 5'($urandom_range(0, 7));
      v.br    = ($urandom_range(0, 7) == 0);
      v.busy  = ($urandom_range(0, 7) == 0);
      applyStimulus(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
